// File: rtl/quiz_pkg.sv
`default_nettype none
// quiz_pkg: phase encoding and shared constants for the quiz round engine.
package quiz_pkg;
  typedef enum logic [2:0] {
    PH_IDLE      = 3'd0,
    PH_GEN       = 3'd1,
    PH_WAIT      = 3'd2,
    PH_JUDGE     = 3'd3,
    PH_RESULT    = 3'd4,
    PH_GAME_OVER = 3'd5
  } phase_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [7:0]  ANS_MOD   = 8'd100;
  localparam int          ANS_W     = 7;
endpackage
`default_nettype wire

// File: rtl/quiz_round_engine_if.sv
`default_nettype none
// quiz_round_engine_if: player-side inputs and display-side outputs of the round engine.
interface quiz_round_engine_if;
  import quiz_pkg::*;

  logic             start;
  logic             op_sel;
  logic [ANS_W-1:0] switch;
  logic             submit;
  logic [ANS_W-1:0] led;
  logic             op_valid;
  logic [2:0]       phase;
  logic             correct;
  logic             wrong;
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_units;
  logic [2:0]       misses;

  modport master (
    output start, op_sel, switch, submit,
    input  led, op_valid, phase, correct, wrong, bcd_tens, bcd_units, misses
  );

  modport slave (
    input  start, op_sel, switch, submit,
    output led, op_valid, phase, correct, wrong, bcd_tens, bcd_units, misses
  );
endinterface
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// lfsr16: 16-bit right-shifting Galois LFSR, one step per adv; a zero seed is replaced by 1.
module lfsr16
  import quiz_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [OUT_W-1:0] q
);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= SEED_EFF;
    end else if (adv) begin
      r_q <= (r_q >> 1) ^ (r_q[0] ? LFSR_MASK : 16'h0000);
    end
  end

  assign q = r_q[OUT_W-1:0];
endmodule
`default_nettype wire

// File: rtl/quiz_round_engine.sv
`default_nettype none
// quiz_round_engine: one mental-arithmetic round after another -- show operands,
// time the answer, judge it, keep a BCD score and a miss count that ends the game.
module quiz_round_engine
  import quiz_pkg::*;
#(
  parameter int          N_OPS    = 4,
  parameter int          OP_W     = 4,
  parameter int          SHOW_CYC = 2,
  parameter int          TIMEOUT  = 16,
  parameter int          RES_CYC  = 4,
  parameter int          MAX_MISS = 3,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  quiz_round_engine_if.slave bus
);
  phase_t           r_state;
  logic [15:0]      r_tmr;
  logic [2:0]       r_idx;
  logic             r_sub;
  logic [ANS_W-1:0] r_acc;
  logic [ANS_W-1:0] r_led;
  logic             r_op_valid;
  logic             r_correct;
  logic             r_wrong;
  logic [3:0]       r_tens;
  logic [3:0]       r_units;
  logic [2:0]       r_misses;

  logic [OP_W-1:0]  w_lfsr;
  logic [ANS_W-1:0] w_op;
  logic             w_show_done, w_wait_done, w_res_done, w_last, w_over;
  logic             w_round_start, w_next_op, w_load, w_sub_now;
  logic [ANS_W-1:0] w_base, w_acc_next;
  logic [7:0]       w_wide;

  // The LFSR steps on the same edge that latches its current value as an operand.
  lfsr16 #(.SEED(SEED), .OUT_W(OP_W)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .adv (w_load),
    .q   (w_lfsr)
  );

  assign w_op          = ANS_W'(w_lfsr);
  assign w_show_done   = (r_tmr == 16'(SHOW_CYC - 1));
  assign w_wait_done   = (r_tmr == 16'(TIMEOUT - 1));
  assign w_res_done    = (r_tmr == 16'(RES_CYC - 1));
  assign w_last        = (r_idx == 3'(N_OPS - 1));
  assign w_over        = (r_misses == 3'(MAX_MISS));
  assign w_round_start = (((r_state == PH_IDLE) || (r_state == PH_GAME_OVER)) && bus.start)
                       || ((r_state == PH_RESULT) && w_res_done && !w_over);
  assign w_next_op     = (r_state == PH_GEN) && w_show_done && !w_last;
  assign w_load        = w_round_start || w_next_op;
  // Next operand index is r_idx+1; odd indices subtract in alternating mode.
  assign w_sub_now     = w_next_op && r_sub && !r_idx[0];

  always_comb begin
    w_base = w_round_start ? '0 : r_acc;
    w_wide = 8'd0;
    if (w_sub_now) begin
      if (w_base < w_op) w_wide = {1'b0, w_base} + ANS_MOD - {1'b0, w_op};
      else               w_wide = {1'b0, w_base} - {1'b0, w_op};
    end else begin
      w_wide = {1'b0, w_base} + {1'b0, w_op};
      if (w_wide >= ANS_MOD) w_wide = w_wide - ANS_MOD;
    end
    w_acc_next = w_wide[ANS_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= PH_IDLE;
      r_tmr      <= '0;
      r_idx      <= '0;
      r_sub      <= 1'b0;
      r_acc      <= '0;
      r_led      <= '0;
      r_op_valid <= 1'b0;
      r_correct  <= 1'b0;
      r_wrong    <= 1'b0;
      r_tens     <= '0;
      r_units    <= '0;
      r_misses   <= '0;
    end else begin
      r_op_valid <= 1'b0;
      r_correct  <= 1'b0;
      r_wrong    <= 1'b0;
      if (w_load) begin
        r_state    <= PH_GEN;
        r_led      <= w_op;
        r_op_valid <= 1'b1;
        r_tmr      <= '0;
        r_acc      <= w_acc_next;
      end
      if (w_round_start) begin
        r_idx <= '0;
        r_sub <= bus.op_sel;
      end
      if (w_next_op) r_idx <= r_idx + 3'd1;
      case (r_state)
        PH_IDLE, PH_GAME_OVER: begin
          if (bus.start) begin
            r_tens   <= '0;
            r_units  <= '0;
            r_misses <= '0;
          end
        end
        PH_GEN: begin
          if (!w_show_done) begin
            r_tmr <= r_tmr + 16'd1;
          end else if (w_last) begin
            r_state <= PH_WAIT;
            r_tmr   <= '0;
            r_led   <= '0;
          end
        end
        PH_WAIT: begin
          // A submit on the final cycle beats the timeout.
          if (bus.submit) begin
            r_state   <= PH_JUDGE;
            r_correct <= (bus.switch == r_acc);
            r_wrong   <= (bus.switch != r_acc);
          end else if (w_wait_done) begin
            r_state <= PH_JUDGE;
            r_wrong <= 1'b1;
          end else begin
            r_tmr <= r_tmr + 16'd1;
          end
        end
        PH_JUDGE: begin
          if (r_correct) begin
            if (r_units == 4'd9) begin
              if (r_tens != 4'd9) begin
                r_units <= 4'd0;
                r_tens  <= r_tens + 4'd1;
              end
            end else begin
              r_units <= r_units + 4'd1;
            end
          end else begin
            r_misses <= r_misses + 3'd1;
          end
          r_state <= PH_RESULT;
          r_led   <= r_acc;
          r_tmr   <= '0;
        end
        PH_RESULT: begin
          if (!w_res_done) begin
            r_tmr <= r_tmr + 16'd1;
          end else if (w_over) begin
            r_state <= PH_GAME_OVER;
            r_led   <= '0;
          end
        end
        default: r_state <= PH_IDLE;
      endcase
    end
  end

  assign bus.led       = r_led;
  assign bus.op_valid  = r_op_valid;
  assign bus.phase     = r_state;
  assign bus.correct   = r_correct;
  assign bus.wrong     = r_wrong;
  assign bus.bcd_tens  = r_tens;
  assign bus.bcd_units = r_units;
  assign bus.misses    = r_misses;
endmodule
`default_nettype wire

// File: tb/tb_quiz_round_engine.sv
`default_nettype none
// tb_quiz_round_engine: randomized rounds checked against an integer-arithmetic game model.
module tb_quiz_round_engine;
  localparam int          N_OPS    = 4;
  localparam int          OP_W     = 4;
  localparam int          SHOW_CYC = 2;
  localparam int          TIMEOUT  = 16;
  localparam int          RES_CYC  = 4;
  localparam int          MAX_MISS = 3;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam int MODE_OK = 0, MODE_VAL = 1, MODE_TO = 2, MODE_WRONG = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  quiz_round_engine_if bus();

  quiz_round_engine #(
    .N_OPS(N_OPS), .OP_W(OP_W), .SHOW_CYC(SHOW_CYC), .TIMEOUT(TIMEOUT),
    .RES_CYC(RES_CYC), .MAX_MISS(MAX_MISS), .SEED(SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_lfsr;
  int          m_score;
  int          m_misses;

  function automatic logic [15:0] lfsr_next(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 0; bus.op_sel = 0; bus.switch = 0; bus.submit = 0;
    rst = 0;
    step(); step();
    rst = 1;
    step();
    m_lfsr = SEED; m_score = 0; m_misses = 0;
    n_tests++;
    if (bus.phase !== 3'd0 || bus.led !== 7'd0 || bus.op_valid !== 1'b0 || bus.correct !== 1'b0
        || bus.wrong !== 1'b0 || bus.bcd_tens !== 4'd0 || bus.bcd_units !== 4'd0 || bus.misses !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: phase=%0d led=%0d ov=%0b c=%0b w=%0b score=%0d%0d misses=%0d, required all 0",
               bus.phase, bus.led, bus.op_valid, bus.correct, bus.wrong, bus.bcd_tens, bus.bcd_units, bus.misses);
    end
  endtask

  // Called in IDLE/GAME_OVER (do_start=1) or in the last RESULT cycle; returns in the last RESULT cycle.
  task automatic run_round(input bit do_start, input bit sel, input int mode, input logic [6:0] val,
                           input int delay, input bit noise);
    int         sum;
    int         waited;
    logic [6:0] op;
    logic [6:0] exp_acc;
    logic [6:0] ans;
    bit         exp_ok;
    bus.op_sel = sel;
    if (do_start) bus.start = 1;
    step();
    bus.start = 0;
    if (do_start) begin
      m_score = 0; m_misses = 0;
      n_tests++;
      if (bus.phase !== 3'd1 || bus.bcd_tens !== 4'd0 || bus.bcd_units !== 4'd0 || bus.misses !== 3'd0) begin
        n_fail++;
        $display("FAIL start_clear: phase=%0d score=%0d%0d misses=%0d, required phase 1 score 00 misses 0",
                 bus.phase, bus.bcd_tens, bus.bcd_units, bus.misses);
      end
    end
    sum = 0;
    for (int k = 0; k < N_OPS; k++) begin
      op = 7'(m_lfsr[OP_W-1:0]);
      m_lfsr = lfsr_next(m_lfsr);
      if (sel && (k % 2 == 1)) sum -= int'(op);
      else                     sum += int'(op);
      n_tests++;
      if (bus.phase !== 3'd1 || bus.op_valid !== 1'b1 || bus.led !== op) begin
        n_fail++;
        $display("FAIL operand%0d: phase=%0d op_valid=%0b led=%0d, required phase 1 op_valid 1 led %0d",
                 k, bus.phase, bus.op_valid, bus.led, op);
      end
      if (noise && k == 0) bus.submit = 1;
      for (int c = 1; c < SHOW_CYC; c++) begin
        step();
        bus.submit = 0;
        n_tests++;
        if (bus.op_valid !== 1'b0 || bus.led !== op) begin
          n_fail++;
          $display("FAIL operand_hold%0d: op_valid=%0b led=%0d, required 0 and %0d", k, bus.op_valid, bus.led, op);
        end
      end
      step();
      bus.submit = 0;
    end
    exp_acc = 7'(((sum % 100) + 100) % 100);
    n_tests++;
    if (bus.phase !== 3'd2) begin
      n_fail++;
      $display("FAIL wait_entry: phase=%0d, required 2", bus.phase);
    end
    if (noise) bus.start = 1;
    if (mode == MODE_TO) begin
      bus.switch = 7'($urandom);
      waited = 0;
      while (bus.phase === 3'd2 && waited < TIMEOUT + 2) begin
        step();
        waited++;
      end
      exp_ok = 0;
      n_tests++;
      if (waited != TIMEOUT) begin
        n_fail++;
        $display("FAIL timeout_len: waited=%0d cycles, required %0d", waited, TIMEOUT);
      end
    end else begin
      if (mode == MODE_OK)       ans = exp_acc;
      else if (mode == MODE_VAL) ans = val;
      else                       ans = 7'((int'(exp_acc) + 1) % 100);
      for (int c = 0; c < delay; c++) step();
      bus.switch = ans;
      bus.submit = 1;
      step();
      bus.submit = 0;
      exp_ok = (ans == exp_acc);
    end
    bus.start = 0;
    n_tests++;
    if (bus.phase !== 3'd3 || bus.correct !== exp_ok || bus.wrong !== !exp_ok) begin
      n_fail++;
      $display("FAIL judge: phase=%0d correct=%0b wrong=%0b, required phase 3 correct=%0b wrong=%0b",
               bus.phase, bus.correct, bus.wrong, exp_ok, !exp_ok);
    end
    if (exp_ok) m_score = (m_score < 99) ? m_score + 1 : 99;
    else        m_misses++;
    step();
    n_tests++;
    if (bus.phase !== 3'd4 || bus.led !== exp_acc || bus.correct !== 1'b0 || bus.wrong !== 1'b0) begin
      n_fail++;
      $display("FAIL result: phase=%0d led=%0d c=%0b w=%0b, required phase 4 led %0d no pulse",
               bus.phase, bus.led, bus.correct, bus.wrong, exp_acc);
    end
    n_tests++;
    if (bus.bcd_tens !== 4'(m_score / 10) || bus.bcd_units !== 4'(m_score % 10) || bus.misses !== 3'(m_misses)) begin
      n_fail++;
      $display("FAIL score: score=%0d%0d misses=%0d, required score %0d misses %0d",
               bus.bcd_tens, bus.bcd_units, bus.misses, m_score, m_misses);
    end
    for (int c = 1; c < RES_CYC; c++) begin
      step();
      n_tests++;
      if (bus.phase !== 3'd4 || bus.led !== exp_acc) begin
        n_fail++;
        $display("FAIL result_hold: phase=%0d led=%0d, required 4 and %0d", bus.phase, bus.led, exp_acc);
      end
    end
  endtask

  task automatic test_add_round();
    run_round(1'b1, 1'b0, MODE_OK, 7'd0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    int cnt = 0;
    while (bus.phase !== 3'd2 && cnt < 40) begin
      step();
      cnt++;
    end
    n_tests++;
    if (bus.phase !== 3'd2) begin
      n_fail++;
      $display("FAIL reach_wait: phase=%0d, required 2", bus.phase);
    end
    rst = 0;
    #1;
    n_tests++;
    if (bus.phase !== 3'd0 || bus.led !== 7'd0 || bus.op_valid !== 1'b0 || bus.bcd_units !== 4'd0
        || bus.bcd_tens !== 4'd0 || bus.misses !== 3'd0 || bus.correct !== 1'b0 || bus.wrong !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: phase=%0d led=%0d score=%0d%0d misses=%0d, required all 0",
               bus.phase, bus.led, bus.bcd_tens, bus.bcd_units, bus.misses);
    end
    step(); step();
    rst = 1;
    step();
    n_tests++;
    if (bus.phase !== 3'd0 || bus.led !== 7'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: phase=%0d led=%0d, required 0 0", bus.phase, bus.led);
    end
    m_lfsr = SEED; m_score = 0; m_misses = 0;
  endtask

  task automatic test_sub_wrap();
    // From the reset seed the alternating sum goes negative and must wrap by +100.
    run_round(1'b1, 1'b1, MODE_OK, 7'd0, 3, 1'b0);
  endtask

  task automatic test_misses();
    run_round(1'b0, 1'b0, MODE_VAL, 7'd120, 2, 1'b0);
    run_round(1'b0, 1'b1, MODE_TO, 7'd0, 0, 1'b0);
    run_round(1'b0, 1'($urandom), MODE_WRONG, 7'd0, 5, 1'b0);
  endtask

  task automatic test_game_over();
    step();
    for (int c = 0; c < 6; c++) begin
      n_tests++;
      if (bus.phase !== 3'd5 || bus.led !== 7'd0 || bus.op_valid !== 1'b0 || bus.correct !== 1'b0
          || bus.wrong !== 1'b0 || bus.misses !== 3'(MAX_MISS)
          || bus.bcd_tens !== 4'(m_score / 10) || bus.bcd_units !== 4'(m_score % 10)) begin
        n_fail++;
        $display("FAIL game_over_hold: phase=%0d led=%0d misses=%0d score=%0d%0d, required 5 0 %0d %0d",
                 bus.phase, bus.led, bus.misses, bus.bcd_tens, bus.bcd_units, MAX_MISS, m_score);
      end
      bus.submit = 1'($urandom);
      bus.op_sel = 1'($urandom);
      step();
    end
    bus.submit = 0;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 100; i++) begin
      run_round(i == 0, 1'($urandom), MODE_OK, 7'd0,
                (i == 5) ? TIMEOUT - 1 : int'($urandom_range(TIMEOUT - 1, 0)), 1'b1);
    end
    n_tests++;
    if (bus.bcd_tens !== 4'd9 || bus.bcd_units !== 4'd9) begin
      n_fail++;
      $display("FAIL saturate: score=%0d%0d, required 99", bus.bcd_tens, bus.bcd_units);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_round();
    test_reset_mid_wait();
    test_sub_wrap();
    test_misses();
    test_game_over();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
